tff_bank_sequencer: RTL and testbench

// - Controller sequencing a bank of WIDTH toggle flip-flops as a programmable modulo-N up/down counter.
// - Generates the per-bit toggle-enable vector each cycle and applies it to the internal T-flop bank (q <= q ^ t_vec).
// - Provides start/stop/resume control, terminal-count wrap and status for timer and divider logic.

---
 rtl/tff_bank_sequencer.sv | 139 +++++++++++++
 tb/tb_tff_bank_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tff_bank_sequencer.sv
// Bank of WIDTH toggle flops sequenced as a modulo-N up/down counter with run/hold/idle control.
// Define TFF_SEQ_ONESHOT_EN to stop in IDLE after the first terminal count and pulse done.
module tff_bank_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             wrap,
  output logic             done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             done_d;
  logic [WIDTH-1:0] mod_m1;
  logic [WIDTH-1:0] cnt_t;
  logic             term;
  logic             run_adv;
  logic             up_all, dn_all;

  assign mod_m1  = mod_q - WIDTH'(1);
  assign term    = dir_q ? (q_q == mod_m1) : (q_q == '0);
  assign run_adv = (state_q == S_RUN) && !stop && !rst;

  // Ripple-style toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    cnt_t  = '0;
    up_all = 1'b1;
    dn_all = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_t[i] = dir_q ? up_all : dn_all;
      up_all   = up_all & q_q[i];
      dn_all   = dn_all & ~q_q[i];
    end
  end

  // At terminal count the enables steer q directly to its wrap value.
  always_comb begin
    t_vec = '0;
    if (run_adv) begin
      if (term) t_vec = dir_q ? q_q : (q_q ^ mod_m1);
      else      t_vec = cnt_t;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mod_d   = mod_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_RUN;
          mod_d   = mod_val;
          dir_d   = up_dn;
          q_d     = up_dn ? '0 : (mod_val - WIDTH'(1));
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_HOLD;
        end else begin
          q_d    = q_q ^ t_vec;
          wrap_d = term;
`ifdef TFF_SEQ_ONESHOT_EN
          if (term) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
`endif
        end
      end
      S_HOLD: begin
        if (stop) begin
          state_d = S_IDLE;
          q_d     = '0;
        end else if (start) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      mod_q   <= '0;
      dir_q   <= 1'b1;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mod_q   <= mod_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef TFF_SEQ_ONESHOT_EN
  logic done_q;
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= done_d;
  end
  assign done = done_q;
`else
  logic unused_done;
  assign unused_done = done_d;
  assign done        = 1'b0;
`endif

  assign q         = q_q;
  assign busy      = (state_q != S_IDLE);
  assign wrap      = wrap_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Testbench for tff_bank_sequencer: constant vector table, directed sequences and random
// stimulus, all compared against an arithmetic modulo-N counter model.
module tb_tff_bank_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, up_dn;
  logic [3:0] mod_val;
  logic [3:0] t_vec, q;
  logic       busy, wrap, done;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  tff_bank_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .up_dn(up_dn),
    .mod_val(mod_val), .t_vec(t_vec), .q(q), .busy(busy), .wrap(wrap),
    .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=idle 1=run 2=hold; count kept as an integer modulo m_n.
  int m_mode = 0;
  int m_q    = 0;
  int m_n    = 16;
  bit m_up   = 1'b1;
  bit m_wrap = 1'b0;
  bit m_done = 1'b0;

  function automatic int model_next();
    if (m_up) return (m_q + 1) % m_n;
    return (m_q == 0) ? (m_n - 1) : (m_q - 1);
  endfunction

  function automatic bit model_term();
    return m_up ? (m_q == m_n - 1) : (m_q == 0);
  endfunction

  function automatic int model_tvec(input bit r, input bit p);
    if (r || m_mode != 1 || p) return 0;
    return (model_next() ^ m_q) & 15;
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit p, input bit u, input int m);
    bit t;
    m_wrap = 1'b0;
    m_done = 1'b0;
    if (r) begin
      m_mode = 0; m_q = 0; m_n = 16; m_up = 1'b1;
    end else if (m_mode == 0) begin
      if (s && !p) begin
        m_mode = 1;
        m_n    = (m == 0) ? 16 : m;
        m_up   = u;
        m_q    = u ? 0 : m_n - 1;
      end
    end else if (m_mode == 1) begin
      if (p) m_mode = 2;
      else begin
        t      = model_term();
        m_q    = model_next();
        m_wrap = t;
`ifdef TFF_SEQ_ONESHOT_EN
        if (t) begin m_mode = 0; m_done = 1'b1; end
`endif
      end
    end else begin
      if (p) begin m_mode = 0; m_q = 0; end
      else if (s) m_mode = 1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check combinational t_vec, clock, check registered outputs.
  task automatic step(input logic r, input logic s, input logic p, input logic u,
                      input logic [3:0] m, output logic [3:0] t_pre);
    @(negedge clk);
    rst = r; start = s; stop = p; up_dn = u; mod_val = m;
    #1;
    t_pre = t_vec;
    check("t_vec", int'(t_vec), model_tvec(r, p));
    @(posedge clk);
    model_edge(r, s, p, u, int'(m));
    #1;
    check("q", int'(q), m_q);
    check("busy", int'(busy), int'(m_mode != 0));
    check("wrap", int'(wrap), int'(m_wrap));
    check("done", int'(done), int'(m_done));
  endtask

  typedef struct {
    logic       rst, start, stop, up_dn;
    logic [3:0] mod_val;
    logic [3:0] exp_tvec, exp_q;
    logic       exp_busy, exp_wrap;
  } vec_t;

  function automatic vec_t mk(input logic r, s, p, u, input logic [3:0] m,
                              input logic [3:0] et, eq, input logic eb, ew);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.up_dn = u; v.mod_val = m;
    v.exp_tvec = et; v.exp_q = eq; v.exp_busy = eb; v.exp_wrap = ew;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    logic [3:0] tp;
    rst = 1'b1; start = 1'b0; stop = 1'b0; up_dn = 1'b1; mod_val = 4'd0;

    // rst start stop up mod | t_vec q busy wrap
    tbl[0]  = mk(0, 1, 0, 1, 4'd10, 4'b0000, 4'd0,  1, 0);
    tbl[1]  = mk(0, 0, 0, 1, 4'd10, 4'b0001, 4'd1,  1, 0);
    tbl[2]  = mk(0, 0, 0, 1, 4'd10, 4'b0011, 4'd2,  1, 0);
    tbl[3]  = mk(0, 0, 0, 1, 4'd10, 4'b0001, 4'd3,  1, 0);
    tbl[4]  = mk(0, 0, 1, 1, 4'd10, 4'b0000, 4'd3,  1, 0);
    tbl[5]  = mk(0, 0, 0, 1, 4'd10, 4'b0000, 4'd3,  1, 0);
    tbl[6]  = mk(0, 0, 0, 1, 4'd10, 4'b0000, 4'd3,  1, 0);
    tbl[7]  = mk(0, 0, 0, 1, 4'd10, 4'b0000, 4'd3,  1, 0);
    tbl[8]  = mk(0, 1, 0, 1, 4'd10, 4'b0000, 4'd3,  1, 0);
    tbl[9]  = mk(0, 0, 0, 1, 4'd10, 4'b0111, 4'd4,  1, 0);
    tbl[10] = mk(0, 0, 0, 1, 4'd10, 4'b0001, 4'd5,  1, 0);
    tbl[11] = mk(0, 1, 1, 1, 4'd10, 4'b0000, 4'd5,  1, 0);
    tbl[12] = mk(0, 0, 1, 1, 4'd10, 4'b0000, 4'd0,  0, 0);
    tbl[13] = mk(0, 1, 1, 1, 4'd10, 4'b0000, 4'd0,  0, 0);
    tbl[14] = mk(0, 0, 1, 1, 4'd10, 4'b0000, 4'd0,  0, 0);
    tbl[15] = mk(0, 1, 0, 0, 4'd0,  4'b0000, 4'd15, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 4'd0,  4'b0001, 4'd14, 1, 0);
    tbl[17] = mk(1, 0, 0, 0, 4'd0,  4'b0000, 4'd0,  0, 0);
    tbl[18] = mk(1, 0, 0, 0, 4'd0,  4'b0000, 4'd0,  0, 0);

    // Reset state
    step(1, 0, 0, 1, 4'd0, tp);
    step(1, 0, 0, 1, 4'd0, tp);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].up_dn, tbl[i].mod_val, tp);
      check($sformatf("tbl%0d_tvec", i), int'(tp),   int'(tbl[i].exp_tvec));
      check($sformatf("tbl%0d_q", i),    int'(q),    int'(tbl[i].exp_q));
      check($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].exp_busy));
      check($sformatf("tbl%0d_wrap", i), int'(wrap), int'(tbl[i].exp_wrap));
    end

    // Up mod 5
    step(0, 1, 0, 1, 4'd5, tp);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 4'd5, tp);
    step(0, 0, 1, 1, 4'd5, tp);
    step(0, 0, 1, 1, 4'd5, tp);

    // Down mod 0 (full 16-state cycle)
    step(0, 1, 0, 0, 4'd0, tp);
    for (int i = 0; i < 20; i++) begin
      if (m_mode == 1 && m_q == 8) begin
        step(0, 0, 0, 0, 4'd0, tp);
        check("down_tvec_at_8", int'(tp), 15);
      end else begin
        step(0, 0, 0, 0, 4'd0, tp);
      end
    end
    step(0, 0, 1, 0, 4'd0, tp);
    step(0, 0, 1, 0, 4'd0, tp);

    // Modulus 1: q pinned at 0, wrap every cycle, no toggles
    step(0, 1, 0, 1, 4'd1, tp);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1, 4'd1, tp);
      check("mod1_tvec_zero", int'(tp), 0);
    end
    step(0, 0, 1, 1, 4'd1, tp);
    step(0, 0, 1, 1, 4'd1, tp);

    // mod_val and up_dn wiggle mid-run; period must stay 6
    step(0, 1, 0, 1, 4'd6, tp);
    for (int i = 0; i < 14; i++)
      step(0, 0, 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), tp);
    step(0, 0, 1, 1, 4'd6, tp);
    step(0, 0, 1, 1, 4'd6, tp);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 99) < 2),
           1'($urandom_range(0, 99) < 20),
           1'($urandom_range(0, 99) < 8),
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), tp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
